clint_timer: RTL
================

Name: clint_timer

Overview:
Core-local interruptor that sources the machine timer and software interrupt requests consumed by the CSR file. It holds the memory-mapped msip, mtimecmp and mtime registers and drives o_timer_int_call and o_software_int_call. These two outputs feed the CSR file's MTIP and MSIP inputs. The core's load/store unit accesses it through a single-beat valid/ready request and response port.

Parameters:
DATA_WIDTH, 64, register and bus data width.
ADDR_WIDTH, 16, byte address width of the block-local offset.
PRESCALE, 1, clk cycles per mtime increment; must be >= 1.

Ports:
clk  in  1  clock
arst  in  1  reset, synchronous, active-high
i_req_valid  in  1  request valid
o_req_ready  out  1  block can accept a request
i_req_write  in  1  1 = write, 0 = read
i_req_addr  in  ADDR_WIDTH  byte offset; bits [2:0] ignored
i_req_wdata  in  DATA_WIDTH  write data
i_req_wstrb  in  DATA_WIDTH/8  byte write enables
o_resp_valid  out  1  response valid
i_resp_ready  in  1  requester accepts response
o_resp_rdata  out  DATA_WIDTH  read data; 0 for writes
o_resp_err  out  1  unmapped address
o_timer_int_call  out  1  mtime >= mtimecmp
o_software_int_call  out  1  msip[0]

Behaviour:
- Clocking and reset: one clock, clk. arst is synchronous and active-high, sampled only on the rising edge of clk.
- Reset values:
  - mtime = 0, mtimecmp = all ones, msip = 0, prescaler count = 0.
  - FSM = IDLE, o_req_ready = 1, o_resp_valid = 0.
  - o_resp_rdata = 0, o_resp_err = 0.
  - o_timer_int_call = 0, o_software_int_call = 0.
- Reset mid-transaction drops any pending response. No response is issued for it.
- Address map, decoded on i_req_addr[ADDR_WIDTH-1:3]:
  - 0x0000: msip. Only bit 0 is writable; other bits read 0.
  - 0x4000: mtimecmp, 64-bit.
  - 0xBFF8: mtime, 64-bit.
  - All other offsets are unmapped.
- Write semantics:
  - Writes apply i_req_wstrb per byte; bytes with a clear strobe keep their old value.
  - msip honours only strobe bit 0.
- FSM:
  - IDLE: o_req_ready = 1. On i_req_valid & o_req_ready, perform the write (or capture read data) that cycle. Go to RESP.
  - RESP: o_req_ready = 0 and o_resp_valid = 1, with rdata/err held stable. On i_resp_ready, go to IDLE.
  - Throughput: one transaction per 2 cycles minimum.
  - Response latency: o_resp_valid asserts on the cycle after acceptance.
- Read data is the register value sampled at acceptance. The mtime snapshot is the pre-increment value of that cycle.
- Unmapped access:
  - Writes have no effect.
  - Reads return 0.
  - o_resp_err = 1 in RESP.
- Prescaler:
  - The counter counts 0 .. PRESCALE-1.
  - When it wraps (count == PRESCALE-1), mtime increments by 1 modulo 2^64. mtime wraps from all ones to 0.
  - With PRESCALE = 1, mtime increments every cycle.
- Simultaneous software write to mtime and a tick in the same cycle:
  - The write wins; the tick is lost for that cycle.
  - The prescaler count is not reset by mtime writes.
- Interrupt outputs:
  - o_timer_int_call is a register loaded every cycle with (mtime >= mtimecmp), unsigned, using the current register values.
  - It therefore lags a register change by 1 cycle.
  - It stays asserted as long as the compare holds. Software clears it by raising mtimecmp or lowering mtime.
  - o_software_int_call is msip[0] driven directly, so it changes the cycle after the write is accepted.
- Outputs are level signals with no edge or pulse behaviour. The CSR file samples them every cycle.

Test Plan:
- Reset: assert arst for 2 cycles, then release -> all outputs 0, o_req_ready = 1. Read 0xBFF8 at the first accepted cycle returns 0; read 0x4000 returns 0xFFFF_FFFF_FFFF_FFFF.
- Timer fire with PRESCALE = 1:
  - Write mtimecmp = 20 at mtime ≈ 5 -> o_timer_int_call rises exactly 1 cycle after mtime reaches 20, and stays high.
  - Then write mtimecmp = 0xFFFF_FFFF_FFFF_FFFF -> o_timer_int_call falls 1 cycle after the write.
- Software interrupt:
  - Write 0x1 to 0x0000 with wstrb = 0x01 -> o_software_int_call = 1 the next cycle.
  - Write 0xFE with wstrb = 0x01 -> it clears; a readback returns 0.
  - Write 0x1 with wstrb = 0x00 -> no change.
- Handshake backpressure: hold i_resp_ready = 0 for 5 cycles after a read -> o_resp_valid, rdata and err stay stable, and o_req_ready stays 0. A second i_req_valid is not accepted until the response completes.
- Prescaler and wrap with PRESCALE = 4:
  - Write mtime = 0xFFFF_FFFF_FFFF_FFFE -> mtime reaches 0 after 8 cycles (two increments, one per 4 cycles).
  - Force a mtime write on a tick cycle -> the written value is kept with no +1.
- Unmapped and partial strobe:
  - Read 0x1000 -> rdata = 0, err = 1.
  - Write mtimecmp with wstrb = 0x0F and data 0x1122_3344_5566_7788 over all ones -> readback 0xFFFF_FFFF_5566_7788.

Source files
------------

// File: rtl/clint_timer_if.sv
// Request/response bus into the core-local interruptor.
// A request transfers on a clock edge where i_req_valid and o_req_ready are both high; the
// response transfers where o_resp_valid and i_resp_ready are both high. A valid, once raised,
// holds its payload stable until the matching transfer edge.
interface clint_timer_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 16
);
  logic                    i_req_valid;
  logic                    o_req_ready;
  logic                    i_req_write;
  logic [ADDR_WIDTH-1:0]   i_req_addr;
  logic [DATA_WIDTH-1:0]   i_req_wdata;
  logic [DATA_WIDTH/8-1:0] i_req_wstrb;
  logic                    o_resp_valid;
  logic                    i_resp_ready;
  logic [DATA_WIDTH-1:0]   o_resp_rdata;
  logic                    o_resp_err;

  modport master (
    output i_req_valid, i_req_write, i_req_addr, i_req_wdata, i_req_wstrb, i_resp_ready,
    input  o_req_ready, o_resp_valid, o_resp_rdata, o_resp_err
  );

  modport slave (
    input  i_req_valid, i_req_write, i_req_addr, i_req_wdata, i_req_wstrb, i_resp_ready,
    output o_req_ready, o_resp_valid, o_resp_rdata, o_resp_err
  );
endinterface

// File: rtl/clint_timer.sv
// Core-local interruptor: msip / mtimecmp / mtime registers with a prescaled mtime counter,
// driving the machine timer and software interrupt levels into the CSR file.
module clint_timer #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 16,
  parameter int PRESCALE   = 1
) (
  input  logic         clk,
  input  logic         arst,
  clint_timer_if.slave bus,
  output logic         o_timer_int_call,
  output logic         o_software_int_call,
  output logic         o_dbg_state
);
  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int SW   = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] MSIP_OFF  = ADDR_WIDTH'(16'h0000);
  localparam logic [ADDR_WIDTH-1:0] CMP_OFF   = ADDR_WIDTH'(16'h4000);
  localparam logic [ADDR_WIDTH-1:0] MTIME_OFF = ADDR_WIDTH'(16'hBFF8);

  typedef enum logic {S_IDLE = 1'b0, S_RESP = 1'b1} state_t;

  state_t                state;
  logic [PS_W-1:0]       ps_cnt;
  logic [DATA_WIDTH-1:0] mtime;
  logic [DATA_WIDTH-1:0] mtimecmp;
  logic                  msip;

  logic                  tick;
  logic                  accept;
  logic                  do_write;
  logic                  sel_msip;
  logic                  sel_cmp;
  logic                  sel_mtime;
  logic                  hit;
  logic [DATA_WIDTH-1:0] rd_mux;
  logic [2:0]            unused_addr_lo;

  function automatic logic [DATA_WIDTH-1:0] merge_bytes(
    input logic [DATA_WIDTH-1:0] old_v,
    input logic [DATA_WIDTH-1:0] new_v,
    input logic [SW-1:0]         strb
  );
    merge_bytes = old_v;
    for (int b = 0; b < SW; b++) begin
      if (strb[b]) merge_bytes[b*8 +: 8] = new_v[b*8 +: 8];
    end
  endfunction

  assign unused_addr_lo = bus.i_req_addr[2:0];
  assign tick      = (ps_cnt == PS_W'(PRESCALE - 1));
  assign accept    = bus.i_req_valid & bus.o_req_ready;
  assign do_write  = accept & bus.i_req_write;
  assign sel_msip  = (bus.i_req_addr[ADDR_WIDTH-1:3] == MSIP_OFF[ADDR_WIDTH-1:3]);
  assign sel_cmp   = (bus.i_req_addr[ADDR_WIDTH-1:3] == CMP_OFF[ADDR_WIDTH-1:3]);
  assign sel_mtime = (bus.i_req_addr[ADDR_WIDTH-1:3] == MTIME_OFF[ADDR_WIDTH-1:3]);
  assign hit       = sel_msip | sel_cmp | sel_mtime;

  // mtime is sampled before this cycle's increment, so reads see the pre-tick value.
  always_comb begin
    rd_mux = '0;
    if (sel_msip)       rd_mux[0] = msip;
    else if (sel_cmp)   rd_mux    = mtimecmp;
    else if (sel_mtime) rd_mux    = mtime;
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      state            <= S_IDLE;
      ps_cnt           <= '0;
      mtime            <= '0;
      mtimecmp         <= '1;
      msip             <= 1'b0;
      o_timer_int_call <= 1'b0;
      bus.o_req_ready  <= 1'b1;
      bus.o_resp_valid <= 1'b0;
      bus.o_resp_rdata <= '0;
      bus.o_resp_err   <= 1'b0;
    end else begin
      ps_cnt           <= tick ? '0 : ps_cnt + PS_W'(1);
      o_timer_int_call <= (mtime >= mtimecmp);

      // A software write to mtime overrides the tick; the prescaler keeps counting.
      if (do_write && sel_mtime) mtime <= merge_bytes(mtime, bus.i_req_wdata, bus.i_req_wstrb);
      else if (tick)             mtime <= mtime + DATA_WIDTH'(1);

      if (do_write && sel_cmp) mtimecmp <= merge_bytes(mtimecmp, bus.i_req_wdata, bus.i_req_wstrb);
      if (do_write && sel_msip && bus.i_req_wstrb[0]) msip <= bus.i_req_wdata[0];

      case (state)
        S_IDLE: begin
          if (accept) begin
            state            <= S_RESP;
            bus.o_req_ready  <= 1'b0;
            bus.o_resp_valid <= 1'b1;
            bus.o_resp_rdata <= bus.i_req_write ? '0 : rd_mux;
            bus.o_resp_err   <= ~hit;
          end
        end
        S_RESP: begin
          if (bus.i_resp_ready) begin
            state            <= S_IDLE;
            bus.o_req_ready  <= 1'b1;
            bus.o_resp_valid <= 1'b0;
            bus.o_resp_rdata <= '0;
            bus.o_resp_err   <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign o_software_int_call = msip;
  assign o_dbg_state         = (state == S_RESP);
endmodule
